// File: rtl/mem_bus_master.sv
// Processor-side initiator for the word-addressable memory bus.
// Issues one load/store at a time, waits for MFC, then returns the bus to high-Z.
module mem_bus_master #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMER_WIDTH    = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req_Valid,
  input  logic        Req_Write,
  input  logic [31:0] Req_Address,
  input  logic [31:0] Req_WriteData,
  output logic        Req_Ready,
  output logic        Resp_Valid,
  output logic [31:0] Resp_ReadData,
  output logic        Resp_Error,
  output logic        Resp_Timeout,
  output logic        Busy,
  output logic [31:0] MEM_Address,
  output logic [31:0] MEM_Data_In,
  output logic [1:0]  MEM_r_w_z_z,
  input  logic [31:0] MEM_Data_Out,
  input  logic        MEM_MFC,
  input  logic        MEM_ERROR
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam logic [1:0] BUS_READ  = 2'b00;
  localparam logic [1:0] BUS_IDLE  = 2'b10;

  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]             state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [1:0]             rwzz_q, rwzz_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   tmo_q, tmo_d;
  logic                   rvalid_q, rvalid_d;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rwzz_d   = rwzz_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    rvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (Req_Valid) begin
          addr_d = Req_Address;
          if (Req_Write) begin
            wdata_d = Req_WriteData;
          end
          rwzz_d  = {1'b0, Req_Write};
          err_d   = 1'b0;
          tmo_d   = 1'b0;
          timer_d = '0;
          state_d = ACCESS;
        end
      end

      // Error beats MFC; every exit path drops the bus to high-Z and restarts the timer.
      ACCESS: begin
        if (MEM_ERROR) begin
          err_d   = 1'b1;
          rwzz_d  = BUS_IDLE;
          timer_d = '0;
          state_d = RELEASE;
        end else if (MEM_MFC) begin
          if (rwzz_q == BUS_READ) begin
            rdata_d = MEM_Data_Out;
          end
          rwzz_d  = BUS_IDLE;
          timer_d = '0;
          state_d = RELEASE;
        end else if (timer_q == TIMER_LAST) begin
          tmo_d   = 1'b1;
          rwzz_d  = BUS_IDLE;
          timer_d = '0;
          state_d = RELEASE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      // Wait for the memory to drop MFC/ERROR before reporting completion.
      RELEASE: begin
        if (!MEM_MFC && !MEM_ERROR) begin
          rvalid_d = 1'b1;
          state_d  = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          tmo_d    = 1'b1;
          rvalid_d = 1'b1;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        rwzz_d  = BUS_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rwzz_q   <= BUS_IDLE;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rwzz_q   <= rwzz_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign Req_Ready     = (state_q == IDLE);
  assign Busy          = (state_q != IDLE);
  assign Resp_Valid    = rvalid_q;
  assign Resp_ReadData = rdata_q;
  assign Resp_Error    = err_q;
  assign Resp_Timeout  = tmo_q;
  assign MEM_Address   = addr_q;
  assign MEM_Data_In   = wdata_q;
  assign MEM_r_w_z_z   = rwzz_q;

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Processor-side initiator for the word-addressable memory interface (MEM_Address / MEM_Data_In / MEM_r_w_z_z / MEM_Data_Out / MEM_MFC / MEM_ERROR).
- Accepts single load/store requests from the control unit and drives the memory bus with registered outputs.
- Waits for Memory Function Complete (MFC), captures read data, then releases the bus to high-impedance.
- Returns a one-cycle completion with error and timeout status.

Parameters:
- TIMEOUT_CYCLES, 4096, maximum cycles spent in ACCESS or in RELEASE before the transfer is aborted.
- TIMER_WIDTH, 16, width of the internal wait timer; TIMEOUT_CYCLES < 2^TIMER_WIDTH.

Ports:
- Clock  in  1  single system clock; all state changes on rising edge.
- Reset  in  1  asynchronous reset, active-high.
- Req_Valid  in  1  control unit requests a transfer.
- Req_Write  in  1  1 = store, 0 = load.
- Req_Address  in  32  word address.
- Req_WriteData  in  32  store data.
- Req_Ready  out  1  master can accept a request this cycle.
- Resp_Valid  out  1  one-cycle completion pulse.
- Resp_ReadData  out  32  captured load data.
- Resp_Error  out  1  memory reported MEM_ERROR (unassigned address).
- Resp_Timeout  out  1  transfer aborted by timer.
- Busy  out  1  state != IDLE.
- MEM_Address  out  32  bus address.
- MEM_Data_In  out  32  bus write data.
- MEM_r_w_z_z  out  2  00 = read, 01 = write, 10 = high-Z/idle.
- MEM_Data_Out  in  32  memory read data.
- MEM_MFC  in  1  memory function complete (level).
- MEM_ERROR  in  1  memory address error (level).

Behaviour:
- Reset (async, immediate) values:
  - MEM_r_w_z_z = 2'b10; MEM_Address = 0; MEM_Data_In = 0.
  - Req_Ready = 1; Resp_Valid = 0; Resp_ReadData = 0; Resp_Error = 0; Resp_Timeout = 0; Busy = 0.
  - timer = 0; state = IDLE.
  - Reset mid-transfer aborts with no Resp_Valid.
- States: IDLE, ACCESS, RELEASE. Req_Ready = (state == IDLE).
- IDLE, on the edge with Req_Valid & Req_Ready:
  - Latch MEM_Address = Req_Address.
  - MEM_Data_In = Req_WriteData for writes; unchanged for reads.
  - MEM_r_w_z_z = {1'b0, Req_Write}.
  - Clear Resp_Error, Resp_Timeout and timer; go to ACCESS.
  - Req_Valid while not ready is ignored (not queued).
- ACCESS: MEM_Address, MEM_Data_In and MEM_r_w_z_z are held stable. Evaluated at each edge, in priority order:
  1. MEM_ERROR = 1: Resp_Error <= 1; go to RELEASE. Error wins over a simultaneous MFC; read data is not captured.
  2. MEM_MFC = 1: on a read, Resp_ReadData <= MEM_Data_Out (unchanged on a write); go to RELEASE.
  3. timer == TIMEOUT_CYCLES-1: Resp_Timeout <= 1; go to RELEASE.
  4. Otherwise timer <= timer + 1.
- Entering RELEASE: MEM_r_w_z_z <= 2'b10 and timer <= 0. Address and data are retained.
- RELEASE (four-phase return-to-zero):
  - When MEM_MFC == 0 and MEM_ERROR == 0 are sampled: Resp_Valid <= 1; go to IDLE.
  - On timer == TIMEOUT_CYCLES-1: Resp_Timeout <= 1, Resp_Valid <= 1; go to IDLE.
  - Otherwise timer increments.
- Resp_Valid:
  - High for exactly one cycle, coinciding with the first IDLE cycle.
  - Resp_ReadData, Resp_Error and Resp_Timeout hold until the next accept.
  - A new request may be accepted in that same cycle (back-to-back).
- Minimum latency: accept at edge E0 → MFC sampled at E1 → MFC low sampled at E2 → Resp_Valid high in the cycle after E2.
- Timer never wraps; it saturates at the compare value.

Test Plan:
1. Read, MFC asserted 3 cycles after the bus is driven and dropped 1 cycle after high-Z (address 0x00000010, MEM_Data_Out = 0xDEADBEEF):
   - MEM_r_w_z_z = 00 during ACCESS, 10 after.
   - Resp_ReadData = 0xDEADBEEF, Resp_Valid one cycle, Resp_Error = 0.
2. Write 0x12345678 to address 0x20, MFC asserted immediately:
   - MEM_r_w_z_z = 01, MEM_Data_In = 0x12345678 stable until MFC.
   - Resp_ReadData unchanged; minimum 3-edge latency met.
3. MEM_ERROR and MEM_MFC raised in the same cycle on a read:
   - Resp_Error = 1, Resp_ReadData not updated, bus to 10.
4. TIMEOUT_CYCLES = 8, MFC never asserted:
   - Exactly 8 cycles in ACCESS, then Resp_Timeout = 1.
   - Bus at 10; Resp_Valid pulses on the next edge, since MFC/ERROR are already low in RELEASE.
5. Req_Valid held high across two requests:
   - Second request is accepted in the Resp_Valid cycle.
   - Req_Valid pulses during ACCESS are ignored.
6. Reset asserted mid-ACCESS:
   - MEM_r_w_z_z = 10 and Req_Ready = 1 immediately, asynchronously.
   - No Resp_Valid; all outputs return to their reset values.
